nibble_serial_sub_ctrl: RTL and testbench

Sequencer that performs a multi-nibble subtraction D = A − B − bin by time-multiplexing one instance of the team's 4-bit borrow-lookahead subtractor cell. Each clock it feeds one nibble pair plus the running borrow to the cell, then captures the cell's difference nibble and borrow-out. It sits between a requesting datapath, connected through a start/done handshake, and the shared subtractor cell. Wide subtractions therefore cost one cell instead of a full-width gate-level array.

---
 rtl/nibble_serial_sub_ctrl.sv | 141 ++++++++++++++
 tb/tb_nibble_serial_sub_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_sub_ctrl.sv
// Multi-nibble subtractor D = A - B - bin, one 4-bit borrow-lookahead cell
// reused over NIBBLES cycles, with a start/ready/done request handshake.

module bla_sub4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  output logic [3:0] d_o,
  output logic       bout_o
);
  logic [3:0] g, p;
  logic [3:0] brw;

  // g: slice generates a borrow; p: slice passes an incoming borrow through
  assign g = ~a_i & b_i;
  assign p = ~(a_i ^ b_i);

  assign brw[0] = bin_i;
  assign brw[1] = g[0] | (p[0] & bin_i);
  assign brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin_i);
  assign brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bin_i);
  assign bout_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin_i);
  assign d_o    = a_i ^ b_i ^ brw;
endmodule

module nibble_serial_sub_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = $clog2(NIBBLES + 1)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         bin_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] d_o,
  output logic         bout_o,
  output logic         zero_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, b_q, acc_q, acc_upd;
  logic          brw_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  d_q;
  logic          bout_q, zero_q;

  logic [3:0]    cell_a, cell_b, cell_d;
  logic          cell_bout;
  logic          accept, last;

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && start_i;
  assign last   = (idx_q == IW'(NIBBLES - 1));

  // Operands stay put; the active slice is picked by idx and written back into acc
  always_comb begin
    cell_a  = '0;
    cell_b  = '0;
    acc_upd = acc_q;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx_q == IW'(k)) begin
        cell_a            = a_q[4*k +: 4];
        cell_b            = b_q[4*k +: 4];
        acc_upd[4*k +: 4] = cell_d;
      end
    end
  end

  bla_sub4 u_cell (
    .a_i   (cell_a),
    .b_i   (cell_b),
    .bin_i (brw_q),
    .d_o   (cell_d),
    .bout_o(cell_bout)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start_i ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b1;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      RUN:  begin ready_o = 1'b0; busy_o = 1'b1; end
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      brw_q  <= 1'b0;
      idx_q  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b1;
    end else if (accept) begin
      a_q   <= a_i;
      b_q   <= b_i;
      brw_q <= bin_i;
      acc_q <= '0;
      idx_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_upd;
      brw_q <= cell_bout;
      idx_q <= idx_q + IW'(1);
      if (last) begin
        d_q    <= acc_upd;
        bout_q <= cell_bout;
        zero_q <= (acc_upd == '0);
      end
    end
  end

  assign d_o    = d_q;
  assign bout_o = bout_q;
  assign zero_o = zero_q;
endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Scoreboard bench: a 4-nibble and a 1-nibble instance, expected results
// queued at issue time and checked when done pulses.

module tb_nibble_serial_sub_ctrl;
  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        zero;
    int          cyc;
  } exp_t;

  logic        clk, rst_n;
  logic        start4, bin4, ready4, busy4, done4, bout4, zero4;
  logic [15:0] a4, b4, d4;
  logic        start1, bin1, ready1, busy1, done1, bout1, zero1;
  logic [3:0]  a1, b1, d1;

  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  exp_t q4[$], q1[$];

  nibble_serial_sub_ctrl #(.NIBBLES(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .a_i(a4), .b_i(b4), .bin_i(bin4),
    .ready_o(ready4), .busy_o(busy4), .done_o(done4), .d_o(d4), .bout_o(bout4), .zero_o(zero4)
  );

  nibble_serial_sub_ctrl #(.NIBBLES(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .a_i(a1), .b_i(b1), .bin_i(bin1),
    .ready_o(ready1), .busy_o(busy1), .done_o(done1), .d_o(d1), .bout_o(bout1), .zero_o(zero1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Result monitors: every done pulse must match the oldest queued request
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done4) begin
      if (q4.size() == 0) chk("d4_spurious_done", 1, 0);
      else begin
        e = q4.pop_front();
        chk("d4_d", 64'(d4), 64'(e.d));
        chk("d4_bout", 64'(bout4), 64'(e.bout));
        chk("d4_zero", 64'(zero4), 64'(e.zero));
        chk("d4_latency", 64'(cyc - e.cyc), 64'd4);
        chk("d4_ready_busy", 64'({ready4, busy4}), 64'b10);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done1) begin
      if (q1.size() == 0) chk("d1_spurious_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("d1_d", 64'(d1), 64'(e.d));
        chk("d1_bout", 64'(bout1), 64'(e.bout));
        chk("d1_zero", 64'(zero1), 64'(e.zero));
        chk("d1_latency", 64'(cyc - e.cyc), 64'd1);
      end
    end
  end

  // Call between edges; the request is accepted on the next rising edge
  task automatic issue4(input logic [15:0] a, input logic [15:0] b, input logic bi);
    exp_t e;
    logic [16:0] r;
    r = {1'b0, a} - {1'b0, b} - 17'(bi);
    e.d = r[15:0]; e.bout = r[16]; e.zero = (r[15:0] == 16'h0); e.cyc = cyc + 1;
    chk("ready4_before_start", 64'(ready4), 64'd1);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    q4.push_back(e);
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic bi);
    exp_t e;
    logic [4:0] r;
    r = {1'b0, a} - {1'b0, b} - 5'(bi);
    e.d = 16'(r[3:0]); e.bout = r[4]; e.zero = (r[3:0] == 4'h0); e.cyc = cyc + 1;
    a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
    q1.push_back(e);
    @(posedge clk); #1 start1 = 1'b0;
  endtask

  task automatic wait4();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done4 && n < 40);
    if (!done4) chk("timeout_done4", 0, 1);
  endtask

  task automatic wait1();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done1 && n < 40);
    if (!done1) chk("timeout_done1", 0, 1);
  endtask

  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic bi);
    issue4(a, b, bi);
    wait4();
    @(negedge clk);
  endtask

  initial begin
    int nb, c1;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    #12;
    chk("rst_ready", 64'(ready4), 64'd1);
    chk("rst_busy_done", 64'({busy4, done4}), 64'd0);
    chk("rst_d", 64'(d4), 64'd0);
    chk("rst_bout_zero", 64'({bout4, zero4}), 64'b01);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Basic case with busy duration
    issue4(16'h1234, 16'h0FFF, 1'b0);
    nb = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done4) break;
      nb += int'(busy4);
    end
    chk("busy_cycles", 64'(nb), 64'd4);
    @(negedge clk);
    chk("done_one_cycle", 64'(done4), 64'd0);

    op4(16'h0000, 16'h0001, 1'b0);
    op4(16'hABCD, 16'hABCD, 1'b0);
    op4(16'h0000, 16'h0000, 1'b1);
    op4(16'hFFFF, 16'h0000, 1'b1);

    // Start during RUN must be dropped
    issue4(16'h5555, 16'h1111, 1'b0);
    @(negedge clk);
    chk("busy_mid_run", 64'(busy4), 64'd1);
    a4 = 16'hFFFF; b4 = 16'h0001; bin4 = 1'b1; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    wait4();
    @(negedge clk);
    chk("no_queued_start", 64'(busy4), 64'd0);
    @(negedge clk);

    // Back-to-back acceptance in the DONE cycle
    issue4(16'h8000, 16'h0001, 1'b0);
    wait4();
    c1 = cyc;
    issue4(16'h00FF, 16'h00FF, 1'b1);
    wait4();
    chk("b2b_gap", 64'(cyc - c1), 64'd5);
    @(negedge clk);

    // Reset after slice 1 is written
    issue4(16'h9999, 16'h1111, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready_busy", 64'({ready4, busy4}), 64'b10);
    chk("midrst_d", 64'(d4), 64'd0);
    chk("midrst_zero_bout", 64'({zero4, bout4}), 64'b10);
    q4.delete();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(done4), 64'd0);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("post_rst_no_done", 64'(done4), 64'd0);
    end
    op4(16'hC0DE, 16'h0ACE, 1'b1);

    for (int i = 0; i < 500; i++) begin
      issue4(16'($urandom), 16'($urandom), 1'($urandom));
      wait4();
      if ($urandom_range(1) == 1) @(negedge clk);
    end
    @(negedge clk);

    for (int i = 0; i < 500; i++) begin
      issue1(4'($urandom), 4'($urandom), 1'($urandom));
      wait1();
      if ($urandom_range(1) == 1) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    chk("q4_drained", 64'(q4.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
